// File: rtl/button_debouncer.sv
// Pushbutton conditioner: 2-FF synchronizer, polarity normalize and per-channel
// debounce counter, with registered level and 1-cycle press/release pulses.
// Optional latched toggle output when BUTTON_DEBOUNCER_TOGGLE_EN is defined.
module button_debouncer #(
  parameter int NUM_BTN        = 2,
  parameter int CLK_HZ         = 27000000,
  parameter int DEBOUNCE_MS    = 10,
  parameter int BTN_ACTIVE_LOW = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_BTN-1:0] btn_raw,
  output logic [NUM_BTN-1:0] btn_level,
  output logic [NUM_BTN-1:0] btn_press,
  output logic [NUM_BTN-1:0] btn_release
`ifdef BUTTON_DEBOUNCER_TOGGLE_EN
  ,
  output logic [NUM_BTN-1:0] btn_toggle
`endif
);

  localparam int CNT_RAW = (CLK_HZ / 1000) * DEBOUNCE_MS;
  localparam int CNT_MAX = (CNT_RAW < 1) ? 1 : CNT_RAW;
  localparam int CW      = $clog2(CNT_MAX + 1);

  localparam logic [CW-1:0] CNT_LAST = CW'(CNT_MAX - 1);
  // Idle pin level, so a held button after reset still needs a full debounce.
  localparam logic          REL_LVL  = (BTN_ACTIVE_LOW != 0) ? 1'b1 : 1'b0;

  logic [NUM_BTN-1:0] sync_q1;
  logic [NUM_BTN-1:0] sync_q2;
  logic [NUM_BTN-1:0] sample;
  logic [CW-1:0]      cnt [NUM_BTN];

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q1 <= {NUM_BTN{REL_LVL}};
      sync_q2 <= {NUM_BTN{REL_LVL}};
    end else begin
      sync_q1 <= btn_raw;
      sync_q2 <= sync_q1;
    end
  end

  assign sample = (BTN_ACTIVE_LOW != 0) ? ~sync_q2 : sync_q2;

  // NOTE: the counter array is small register state, not RAM, so it is reset
  // with everything else to discard any in-flight count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_BTN; i++) cnt[i] <= '0;
      btn_level   <= '0;
      btn_press   <= '0;
      btn_release <= '0;
    end else begin
      btn_press   <= '0;
      btn_release <= '0;
      for (int i = 0; i < NUM_BTN; i++) begin
        if (sample[i] == btn_level[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_LAST) begin
          cnt[i]         <= '0;
          btn_level[i]   <= sample[i];
          btn_press[i]   <= sample[i];
          btn_release[i] <= ~sample[i];
        end else begin
          cnt[i] <= cnt[i] + CW'(1);
        end
      end
    end
  end

`ifdef BUTTON_DEBOUNCER_TOGGLE_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) btn_toggle <= '0;
    else        btn_toggle <= btn_toggle ^ btn_press;
  end
`endif

endmodule

// File: tb/tb_button_debouncer.sv
// Self-checking bench for button_debouncer (CNT_MAX=4): directed stimulus pushes
// expected output events to a scoreboard; a negedge monitor pops and compares.
module tb_button_debouncer;

  typedef struct {
    int         at;
    logic [1:0] lvl;
    logic [1:0] prs;
    logic [1:0] rel;
  } ev_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] btn_raw;
  logic [1:0] btn_level;
  logic [1:0] btn_press;
  logic [1:0] btn_release;
`ifdef BUTTON_DEBOUNCER_TOGGLE_EN
  logic [1:0] btn_toggle;
`endif

  int  n = 0;
  int  checks = 0;
  int  errors = 0;
  ev_t sb[$];

  logic [1:0] exp_lvl = 2'b00;
  logic [1:0] exp_prs;
  logic [1:0] exp_rel;
  logic [1:0] exp_tog = 2'b00;
  logic [1:0] tog_pend = 2'b00;
  ev_t        ev;

  button_debouncer #(
    .NUM_BTN       (2),
    .CLK_HZ        (1000),
    .DEBOUNCE_MS   (4),
    .BTN_ACTIVE_LOW(1)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .btn_raw    (btn_raw),
    .btn_level  (btn_level),
    .btn_press  (btn_press),
    .btn_release(btn_release)
`ifdef BUTTON_DEBOUNCER_TOGGLE_EN
    ,
    .btn_toggle (btn_toggle)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) n++;

  task automatic check(input string tag, input logic [1:0] obs, input logic [1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s at edge %0d: observed=%b expected=%b", tag, n, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic push(input int dly, input logic [1:0] lvl, input logic [1:0] prs,
                      input logic [1:0] rel);
    ev_t e;
    e.at  = n + dly;
    e.lvl = lvl;
    e.prs = prs;
    e.rel = rel;
    sb.push_back(e);
  endtask

  // Monitor: expected outputs for the edge just completed.
  always @(negedge clk) begin
    exp_prs = 2'b00;
    exp_rel = 2'b00;
    if (!rst_n) begin
      exp_lvl  = 2'b00;
      exp_tog  = 2'b00;
      tog_pend = 2'b00;
    end else begin
      exp_tog = exp_tog ^ tog_pend;
      if (sb.size() > 0 && sb[0].at <= n) begin
        ev = sb.pop_front();
        checks++;
        assert (ev.at === n) else begin
          errors++;
          $error("FAIL event_edge: observed=%0d expected=%0d", n, ev.at);
        end
        exp_lvl = ev.lvl;
        exp_prs = ev.prs;
        exp_rel = ev.rel;
      end
      tog_pend = exp_prs;
    end
    check("btn_level", btn_level, exp_lvl);
    check("btn_press", btn_press, exp_prs);
    check("btn_release", btn_release, exp_rel);
    checks++;
    assert ((btn_press & btn_release) === 2'b00) else begin
      errors++;
      $error("FAIL press_and_release: observed=%b expected=00", btn_press & btn_release);
    end
`ifdef BUTTON_DEBOUNCER_TOGGLE_EN
    check("btn_toggle", btn_toggle, exp_tog);
`endif
  end

  initial begin
    // Reset with both buttons held; press only after the full debounce.
    rst_n   = 1'b0;
    btn_raw = 2'b00;
    repeat (5) step();
    rst_n = 1'b1;
    push(6, 2'b11, 2'b11, 2'b00);
    repeat (8) step();

    btn_raw = 2'b11;
    push(6, 2'b00, 2'b00, 2'b11);
    repeat (10) step();

    // Clean press/release on channel 0.
    btn_raw = 2'b10;
    push(6, 2'b01, 2'b01, 2'b00);
    repeat (20) step();
    btn_raw = 2'b11;
    push(6, 2'b00, 2'b00, 2'b01);
    repeat (10) step();

    // 3-cycle glitch on channel 1 must be ignored.
    btn_raw = 2'b01;
    repeat (3) step();
    btn_raw = 2'b11;
    repeat (10) step();

    // Bounce on channel 0, then a steady hold.
    for (int i = 0; i < 10; i++) begin
      btn_raw = {1'b1, i[0]};
      step();
    end
    btn_raw = 2'b10;
    push(6, 2'b01, 2'b01, 2'b00);
    repeat (10) step();

    // Asynchronous reset drops a held level without a clock edge.
    rst_n = 1'b0;
    #1;
    check("async_rst_level", btn_level, 2'b00);
    check("async_rst_press", btn_press, 2'b00);
    check("async_rst_release", btn_release, 2'b00);
    btn_raw = 2'b11;
    repeat (2) step();
    rst_n = 1'b1;
    repeat (4) step();

    // Reset mid-count discards partial progress.
    btn_raw = 2'b10;
    repeat (3) step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    push(6, 2'b01, 2'b01, 2'b00);
    repeat (10) step();

    // Three press/release cycles on channel 1 (channel 0 stays held).
    for (int k = 0; k < 3; k++) begin
      btn_raw = 2'b00;
      push(6, 2'b11, 2'b10, 2'b00);
      repeat (12) step();
      btn_raw = 2'b10;
      push(6, 2'b01, 2'b00, 2'b10);
      repeat (12) step();
    end

    checks++;
    assert (sb.size() === 0) else begin
      errors++;
      $error("FAIL scoreboard_drain: observed=%0d expected=0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/button_debouncer.md
Name: button_debouncer

Overview:
- Upstream input-conditioning stage for the logic-gate demo.
- Takes raw, asynchronous, bouncing board pushbuttons and produces clean, synchronous, pressed-high levels. Those levels drive the gate-evaluation block's a/b inputs directly.
- Also emits single-cycle press/release pulses for future counter/FSM consumers.

Parameters:
- NUM_BTN, 2, number of independent button channels.
- CLK_HZ, 27000000, clk frequency in Hz.
- DEBOUNCE_MS, 10, required stable time in ms.
- BTN_ACTIVE_LOW, 1, 1 = raw pin reads 0 when pressed; 0 = raw pin reads 1 when pressed.
- Derived constant CNT_MAX = (CLK_HZ/1000)*DEBOUNCE_MS, clamped to a minimum of 1.
- Counter width is $clog2(CNT_MAX+1).

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- btn_raw  input  NUM_BTN  raw pushbutton pins; asynchronous; may bounce.
- btn_level  output  NUM_BTN  debounced level; 1 = pressed.
- btn_press  output  NUM_BTN  1-cycle pulse on each debounced 0->1 transition.
- btn_release  output  NUM_BTN  1-cycle pulse on each debounced 1->0 transition.

Behaviour:
- Interface: one clock, clk. Reset rst_n is asynchronous, active-low. All state is cleared on rst_n assertion regardless of clk.
- Reset values:
  - btn_level, btn_press, btn_release = 0.
  - All counters = 0.
  - Synchronizer flops = released level (1 if BTN_ACTIVE_LOW, else 0).
- Per-channel pipeline, channels fully independent:
  - 2-FF synchronizer on btn_raw[i].
  - Polarity normalize to pressed=1, giving sample s[i].
  - Debounce counter cnt[i].
  - Registered stable level lvl[i], which drives btn_level[i].
- Counter rules, evaluated every rising edge:
  - If s == lvl: cnt <= 0.
  - If s != lvl and cnt < CNT_MAX-1: cnt <= cnt+1.
  - If s != lvl and cnt == CNT_MAX-1: lvl <= s, cnt <= 0. On the same edge, btn_press <= s and btn_release <= ~s.
- Pulses are deasserted on every edge where no flip occurs, so each pulse is exactly 1 cycle.
- btn_press and btn_release are never both high on the same channel.
- Effective per-channel states: RELEASED_STABLE (lvl=0, cnt=0), PRESS_PENDING (lvl=0, cnt>0), PRESSED_STABLE (lvl=1, cnt=0), RELEASE_PENDING (lvl=1, cnt>0).
  - Any sample equal to lvl while PENDING returns to the STABLE state of the same level.
- Latency:
  - The raw pin is first sampled at edge E; s changes after E+1.
  - lvl and pulse update at edge E+1+CNT_MAX, i.e. CNT_MAX+2 edges after raw is first sampled, provided raw stays stable throughout.
- Boundary conditions:
  - Any raw disturbance shorter than CNT_MAX cycles (post-sync) produces no output change.
  - A bounce during PENDING restarts the count from 0; there is no partial credit.
  - Simultaneous transitions on multiple channels are handled in parallel; pulses may coincide across channels.
  - Counter cannot overflow: maximum value is CNT_MAX-1.
  - rst_n asserted mid-count: outputs drop to 0 asynchronously and the count is discarded.
  - After rst_n release with a button held, the press is reported after the full debounce period, never immediately.
- No combinational path from btn_raw to any output; all outputs are registered.

Optional Feature:
- Macro: BUTTON_DEBOUNCER_TOGGLE_EN.
- Defined:
  - Adds output port btn_toggle [NUM_BTN], reset value 0.
  - btn_toggle[i] inverts on the edge after each btn_press[i] pulse; release has no effect.
  - Gives latched on/off behaviour for LED demos.
- Undefined: port and its flops are absent; all other behaviour is identical.

Test Plan:
- Bench config for all scenarios: CLK_HZ=1000, DEBOUNCE_MS=4 (CNT_MAX=4), NUM_BTN=2, BTN_ACTIVE_LOW=1.
- Reset with button held:
  - Stimulus: rst_n=0 for 5 cycles, btn_raw=2'b00.
  - Required: all outputs 0 during reset.
  - After release, btn_level goes 2'b11 with btn_press=2'b11 for 1 cycle, exactly 6 edges after the first post-reset edge.
- Clean press and release, channel 0:
  - Stimulus: btn_raw[0] 1->0, held 20 cycles, then 0->1.
  - Required: btn_level[0] rises 6 edges after the change, with a 1-cycle btn_press[0]. It falls 6 edges after release, with a 1-cycle btn_release[0].
  - Channel 1 outputs stay 0 throughout.
- Glitch rejection:
  - Stimulus: btn_raw[1] low for 3 cycles, then high.
  - Required: btn_level[1] stays 0; no pulses.
- Bounce:
  - Stimulus: btn_raw[0] alternates every cycle for 10 cycles, then holds 0.
  - Required: exactly one btn_press[0], 6 edges after the hold begins; btn_release never pulses.
- Mid-count reset:
  - Stimulus: btn_raw[0]=0 for 3 cycles, rst_n pulsed low for 1 cycle, raw kept 0.
  - Required: no pulse before reset; btn_press[0] occurs 6 edges after reset release.
- Toggle (macro defined):
  - Stimulus: three press/release cycles on channel 1.
  - Required: btn_toggle[1] sequence is 0->1->0->1, each change 1 edge after the corresponding btn_press[1].
